uart_rx: RTL and testbench

//  Receives 8N1-style UART frames, oversampled at 8x baud. Consumes the clk_rx strobe from baud_gen.
//  clk_rx is a level signal at 8x baud in the clk domain. It is edge-detected here, never used as a clock.

---
 rtl/uart_rx.sv | 211 +++++++++++++++++++++
 tb/tb_uart_rx.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx
// Purpose  : 8x-oversampled UART receiver (start, DATA_BITS data LSB first,
//            optional parity, one stop bit). Received words are delivered
//            through a one-deep valid/ready holding register with frame,
//            parity and overrun flags.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clk_rx,
  input  logic                 rx,
  input  logic                 rx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam logic       c_par_en   = (PARITY_EN != 0);
  localparam logic       c_par_odd  = (PARITY_ODD != 0);
  localparam logic [3:0] c_last_bit = 4'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4,
    S_BREAK  = 3'd5
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [2:0]             r_tick_cnt;
  logic [2:0]             w_tick_cnt_nxt;
  logic [3:0]             r_bit_cnt;
  logic [3:0]             w_bit_cnt_nxt;
  logic [DATA_BITS-1:0]   r_shift;
  logic [DATA_BITS-1:0]   w_shift_nxt;
  logic                   r_perr;
  logic                   w_perr_nxt;
  logic                   w_deliver;

  logic                   r_clk_rx_q;
  logic                   r_rx_meta;
  logic                   r_rx_s;
  logic                   w_tick;
  logic                   w_consume;
  logic                   w_load;
  logic                   w_drop;

  logic [DATA_BITS-1:0]   r_rx_data;
  logic                   r_rx_valid;
  logic                   r_frame_err;
  logic                   r_parity_err;
  logic                   r_overrun;

  // Rising edge of the 8x-baud level gives a one-clk sampling strobe.
  assign w_tick = clk_rx & ~r_clk_rx_q;

  // clk_rx history flop and two-flop synchronizer for the asynchronous line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_clk_rx_q <= 1'b0;
      r_rx_meta  <= 1'b1;
      r_rx_s     <= 1'b1;
    end else begin
      r_clk_rx_q <= clk_rx;
      r_rx_meta  <= rx;
      r_rx_s     <= r_rx_meta;
    end
  end

  // State, counters and shift register; everything below IDLE is discarded on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_tick_cnt <= 3'd0;
      r_bit_cnt  <= 4'd0;
      r_shift    <= '0;
      r_perr     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_tick_cnt <= w_tick_cnt_nxt;
      r_bit_cnt  <= w_bit_cnt_nxt;
      r_shift    <= w_shift_nxt;
      r_perr     <= w_perr_nxt;
    end
  end

  // Next-state logic: all sampling happens on tick cycles only.
  always_comb begin
    w_state_nxt    = r_state;
    w_tick_cnt_nxt = r_tick_cnt;
    w_bit_cnt_nxt  = r_bit_cnt;
    w_shift_nxt    = r_shift;
    w_perr_nxt     = r_perr;
    w_deliver      = 1'b0;
    if (w_tick) begin
      case (r_state)
        S_IDLE: begin
          if (!r_rx_s) begin
            w_state_nxt    = S_START;
            w_tick_cnt_nxt = 3'd0;
          end
        end
        S_START: begin
          if (r_tick_cnt == 3'd3) begin
            // Start bit still low at its midpoint: a real frame, else a glitch.
            if (!r_rx_s) begin
              w_state_nxt    = S_DATA;
              w_tick_cnt_nxt = 3'd0;
              w_bit_cnt_nxt  = 4'd0;
              w_perr_nxt     = 1'b0;
            end else begin
              w_state_nxt    = S_IDLE;
            end
          end else begin
            w_tick_cnt_nxt = r_tick_cnt + 3'd1;
          end
        end
        S_DATA: begin
          if (r_tick_cnt == 3'd7) begin
            w_shift_nxt    = {r_rx_s, r_shift[DATA_BITS-1:1]};
            w_bit_cnt_nxt  = r_bit_cnt + 4'd1;
            w_tick_cnt_nxt = 3'd0;
            if (r_bit_cnt == c_last_bit) begin
              w_state_nxt = c_par_en ? S_PARITY : S_STOP;
            end
          end else begin
            w_tick_cnt_nxt = r_tick_cnt + 3'd1;
          end
        end
        S_PARITY: begin
          if (r_tick_cnt == 3'd7) begin
            w_perr_nxt     = (^r_shift) ^ r_rx_s ^ c_par_odd;
            w_tick_cnt_nxt = 3'd0;
            w_state_nxt    = S_STOP;
          end else begin
            w_tick_cnt_nxt = r_tick_cnt + 3'd1;
          end
        end
        S_STOP: begin
          if (r_tick_cnt == 3'd7) begin
            w_deliver      = 1'b1;
            w_tick_cnt_nxt = 3'd0;
            w_state_nxt    = r_rx_s ? S_IDLE : S_BREAK;
          end else begin
            w_tick_cnt_nxt = r_tick_cnt + 3'd1;
          end
        end
        S_BREAK: begin
          // Line must return high before another start edge is accepted.
          if (r_rx_s) begin
            w_state_nxt = S_IDLE;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  assign w_consume = r_rx_valid & rx_ready;
  assign w_load    = w_deliver & (~r_rx_valid | w_consume);
  assign w_drop    = w_deliver & ~w_load;

  // One-deep holding register: a delivery wins over a same-cycle consume.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_data    <= '0;
      r_rx_valid   <= 1'b0;
      r_frame_err  <= 1'b0;
      r_parity_err <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      if (w_load) begin
        r_rx_data    <= r_shift;
        r_frame_err  <= ~r_rx_s;
        r_parity_err <= r_perr;
        r_rx_valid   <= 1'b1;
      end else if (w_consume) begin
        r_rx_valid   <= 1'b0;
      end
      if (w_drop) begin
        r_overrun <= 1'b1;
      end else if (w_consume) begin
        r_overrun <= 1'b0;
      end
    end
  end

  assign rx_data    = r_rx_data;
  assign rx_valid   = r_rx_valid;
  assign frame_err  = r_frame_err;
  assign parity_err = r_parity_err;
  assign overrun    = r_overrun;
  assign busy       = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx
// Purpose  : Directed self-checking bench for uart_rx (plain and odd-parity
//            instances sharing clock, reset and the 8x-baud strobe).
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

  logic       clk;
  logic       rst_n;
  logic       clk_rx;
  logic       rx;
  logic       rx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       parity_err;
  logic       overrun;
  logic       busy;

  logic       rx_p;
  logic       rx_ready_p;
  logic [7:0] rx_data_p;
  logic       rx_valid_p;
  logic       frame_err_p;
  logic       parity_err_p;
  logic       overrun_p;
  logic       busy_p;

  int         total;
  int         bad;
  int         vcnt;
  int         vcnt_p;
  logic [7:0] cap_data;
  logic       cap_fe;
  logic       cap_pe;
  logic       cap_ov;
  logic [7:0] cap_data_p;
  logic       cap_pe_p;

  uart_rx #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clk_rx     (clk_rx),
    .rx         (rx),
    .rx_ready   (rx_ready),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .overrun    (overrun),
    .busy       (busy)
  );

  uart_rx #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1)) dut_p (
    .clk        (clk),
    .rst_n      (rst_n),
    .clk_rx     (clk_rx),
    .rx         (rx_p),
    .rx_ready   (rx_ready_p),
    .rx_data    (rx_data_p),
    .rx_valid   (rx_valid_p),
    .frame_err  (frame_err_p),
    .parity_err (parity_err_p),
    .overrun    (overrun_p),
    .busy       (busy_p)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // 8x-baud strobe: high for one clk in every four.
  initial begin
    clk_rx = 1'b0;
    forever begin
      repeat (3) @(posedge clk);
      #1 clk_rx = 1'b1;
      @(posedge clk);
      #1 clk_rx = 1'b0;
    end
  end

  // Count valid cycles and capture the word seen while valid.
  always @(negedge clk) begin
    if (rx_valid) begin
      vcnt     = vcnt + 1;
      cap_data = rx_data;
      cap_fe   = frame_err;
      cap_pe   = parity_err;
      cap_ov   = overrun;
    end
    if (rx_valid_p) begin
      vcnt_p     = vcnt_p + 1;
      cap_data_p = rx_data_p;
      cap_pe_p   = parity_err_p;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // One serial bit lasting 'ticks' strobe periods; returns 1 time unit after a posedge.
  task automatic send_bit(input bit use_p, input logic b, input int ticks);
    if (use_p) rx_p = b;
    else       rx   = b;
    repeat (ticks * 4) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input bit use_p, input logic [7:0] d, input bit pen,
                            input logic pbit, input logic stop_b);
    logic [7:0] v;
    v = d;
    send_bit(use_p, 1'b0, 8);
    for (int i = 0; i < 8; i++) send_bit(use_p, v[i], 8);
    if (pen) send_bit(use_p, pbit, 8);
    send_bit(use_p, stop_b, 8);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    if (rx_data !== 8'h00) begin bad++; $display("FAIL reset_data got=%h exp=00", rx_data); end
    total++;
    if ({rx_valid, frame_err, parity_err, overrun} !== 4'b0000) begin
      bad++; $display("FAIL reset_flags got=%b exp=0000", {rx_valid, frame_err, parity_err, overrun});
    end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++;
    rst_n = 1'b1;
    send_bit(1'b0, 1'b1, 4);
  endtask

  task automatic test_basic;
    int base;
    rx_ready = 1'b1;
    base = vcnt;
    send_frame(1'b0, 8'hA5, 1'b0, 1'b0, 1'b1);
    send_bit(1'b0, 1'b1, 8);
    if (vcnt - base !== 1) begin bad++; $display("FAIL basic_valid_cycles got=%0d exp=1", vcnt - base); end
    total++;
    if (cap_data !== 8'hA5) begin bad++; $display("FAIL basic_data got=%h exp=a5", cap_data); end
    total++;
    if ({cap_fe, cap_pe, cap_ov} !== 3'b000) begin
      bad++; $display("FAIL basic_flags got=%b exp=000", {cap_fe, cap_pe, cap_ov});
    end
    total++;
    if (rx_valid !== 1'b0) begin bad++; $display("FAIL basic_valid_after got=%b exp=0", rx_valid); end
    total++;
  endtask

  task automatic test_glitch;
    int base;
    base = vcnt;
    rx = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    if (busy !== 1'b1) begin bad++; $display("FAIL glitch_busy_start got=%b exp=1", busy); end
    total++;
    rx = 1'b1;
    repeat (24) @(posedge clk);
    #1;
    if (busy !== 1'b0) begin bad++; $display("FAIL glitch_busy_fall got=%b exp=0", busy); end
    total++;
    send_bit(1'b0, 1'b1, 8);
    if (vcnt !== base) begin bad++; $display("FAIL glitch_no_valid got=%0d exp=%0d", vcnt, base); end
    total++;
  endtask

  task automatic test_break;
    int base;
    rx_ready = 1'b1;
    base = vcnt;
    send_frame(1'b0, 8'h3C, 1'b0, 1'b0, 1'b0);
    send_bit(1'b0, 1'b0, 20);
    if (vcnt - base !== 1) begin bad++; $display("FAIL break_valid_cycles got=%0d exp=1", vcnt - base); end
    total++;
    if (cap_data !== 8'h3C) begin bad++; $display("FAIL break_data got=%h exp=3c", cap_data); end
    total++;
    if (cap_fe !== 1'b1) begin bad++; $display("FAIL break_frame_err got=%b exp=1", cap_fe); end
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL break_busy_held got=%b exp=1", busy); end
    total++;
    send_bit(1'b0, 1'b1, 4);
    if (busy !== 1'b0) begin bad++; $display("FAIL break_release got=%b exp=0", busy); end
    total++;
    send_bit(1'b0, 1'b1, 8);
    if (vcnt - base !== 1) begin bad++; $display("FAIL break_no_extra got=%0d exp=1", vcnt - base); end
    total++;
  endtask

  task automatic test_overrun;
    rx_ready = 1'b0;
    send_frame(1'b0, 8'h11, 1'b0, 1'b0, 1'b1);
    send_bit(1'b0, 1'b1, 8);
    if (overrun !== 1'b0) begin bad++; $display("FAIL ovr_first_no_ovr got=%b exp=0", overrun); end
    total++;
    send_frame(1'b0, 8'h22, 1'b0, 1'b0, 1'b1);
    send_bit(1'b0, 1'b1, 8);
    if (rx_valid !== 1'b1) begin bad++; $display("FAIL ovr_valid got=%b exp=1", rx_valid); end
    total++;
    if (rx_data !== 8'h11) begin bad++; $display("FAIL ovr_data got=%h exp=11", rx_data); end
    total++;
    if (overrun !== 1'b1) begin bad++; $display("FAIL ovr_flag got=%b exp=1", overrun); end
    total++;
    rx_ready = 1'b1;
    @(posedge clk);
    #1;
    rx_ready = 1'b0;
    if (rx_valid !== 1'b0) begin bad++; $display("FAIL ovr_consume_valid got=%b exp=0", rx_valid); end
    total++;
    if (overrun !== 1'b0) begin bad++; $display("FAIL ovr_consume_flag got=%b exp=0", overrun); end
    total++;
  endtask

  task automatic test_parity;
    int base;
    rx_ready_p = 1'b1;
    base = vcnt_p;
    send_frame(1'b1, 8'h07, 1'b1, 1'b0, 1'b1);
    send_bit(1'b1, 1'b1, 8);
    if (vcnt_p - base !== 1) begin bad++; $display("FAIL par_good_cycles got=%0d exp=1", vcnt_p - base); end
    total++;
    if (cap_data_p !== 8'h07) begin bad++; $display("FAIL par_good_data got=%h exp=07", cap_data_p); end
    total++;
    if (cap_pe_p !== 1'b0) begin bad++; $display("FAIL par_good_perr got=%b exp=0", cap_pe_p); end
    total++;
    send_frame(1'b1, 8'h07, 1'b1, 1'b1, 1'b1);
    send_bit(1'b1, 1'b1, 8);
    if (vcnt_p - base !== 2) begin bad++; $display("FAIL par_bad_cycles got=%0d exp=2", vcnt_p - base); end
    total++;
    if (cap_pe_p !== 1'b1) begin bad++; $display("FAIL par_bad_perr got=%b exp=1", cap_pe_p); end
    total++;
  endtask

  task automatic test_reset_mid;
    int base;
    logic [7:0] v;
    rx_ready = 1'b1;
    base = vcnt;
    v = 8'hC3;
    send_bit(1'b0, 1'b0, 8);
    for (int i = 0; i < 4; i++) send_bit(1'b0, v[i], 8);
    send_bit(1'b0, v[4], 4);
    if (busy !== 1'b1) begin bad++; $display("FAIL rmid_busy_before got=%b exp=1", busy); end
    total++;
    rst_n = 1'b0;
    #2;
    if ({rx_data, rx_valid, frame_err, parity_err, overrun, busy} !== 13'd0) begin
      bad++; $display("FAIL rmid_outputs got=%h exp=0", {rx_data, rx_valid, frame_err, parity_err, overrun, busy});
    end
    total++;
    rx = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    if ({rx_valid, busy} !== 2'b00) begin bad++; $display("FAIL rmid_held got=%b exp=00", {rx_valid, busy}); end
    total++;
    rst_n = 1'b1;
    send_bit(1'b0, 1'b1, 16);
    if (vcnt !== base) begin bad++; $display("FAIL rmid_no_partial got=%0d exp=%0d", vcnt, base); end
    total++;
    send_frame(1'b0, 8'h5A, 1'b0, 1'b0, 1'b1);
    send_bit(1'b0, 1'b1, 8);
    if (vcnt - base !== 1) begin bad++; $display("FAIL rmid_after_cycles got=%0d exp=1", vcnt - base); end
    total++;
    if (cap_data !== 8'h5A) begin bad++; $display("FAIL rmid_after_data got=%h exp=5a", cap_data); end
    total++;
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    vcnt       = 0;
    vcnt_p     = 0;
    cap_data   = 8'h00;
    cap_fe     = 1'b0;
    cap_pe     = 1'b0;
    cap_ov     = 1'b0;
    cap_data_p = 8'h00;
    cap_pe_p   = 1'b0;
    rst_n      = 1'b0;
    rx         = 1'b1;
    rx_p       = 1'b1;
    rx_ready   = 1'b0;
    rx_ready_p = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_basic();
    test_glitch();
    test_break();
    test_overrun();
    test_parity();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
